ppg_afe_emulator: RTL and testbench

- Synthesizable closed-loop model of the photodiode/DC-compensation/PGA/ADC front end. It sits on the ADC side of the pulse-oximeter settings controller.
- Consumes the controller's LED select, LED_DRIVE, DC_Comp and PGA_Gain outputs and produces the 8-bit ADC code the controller samples.
- Generates a free-running synthetic PPG pulse, so DC-search and PGA-search loops can run on FPGA and in simulation without analog hardware.

---
 rtl/ppg_pkg.sv | 41 ++++
 rtl/ppg_afe_emulator_pulse.sv | 55 +++++
 rtl/ppg_afe_emulator.sv | 189 ++++++++++++++++++
 tb/tb_ppg_afe_emulator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// Shared definitions for the PPG analog front-end emulator.
// - Channel encoding for the LED select and the emulator FSM states.
// - ADC code limits and mid-scale.
// - Widths shared with the settings controller (LED_DRIVE, DC_Comp, PGA_Gain).
// - Internal datapath widths for the pulse shape and the arithmetic stages.
package ppg_pkg;

  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_RED  = 2'd1,
    CH_IR   = 2'd2
  } ch_e;

  typedef enum logic [1:0] {
    ST_DARK   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2
  } st_e;

  localparam int ADC_W   = 8;
  localparam int ADC_MID = 128;
  localparam int ADC_MIN = 0;
  localparam int ADC_MAX = 255;

  localparam int DRIVE_W = 4;
  localparam int COMP_W  = 7;
  localparam int PGA_W   = 4;
  localparam int T_W     = 6;
  localparam int DIFF_W  = 12;
  localparam int AMP_W   = 17;

  // A conflicting select (both LEDs on) is treated as no light at all.
  function automatic ch_e decode_sel(input logic red, input logic ir);
    case ({red, ir})
      2'b10:   return CH_RED;
      2'b01:   return CH_IR;
      default: return CH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ppg_afe_emulator_pulse.sv
// Free-running synthetic pulse shape generator.
// Ports:
//   CLK, rst_n : clock, async active-low reset
//   t          : 6-bit pulse shape, ramps 0->63 (RISE_DIV cycles/step) then 63->0 (FALL_DIV cycles/step)
//   beat       : one-cycle strobe in the cycle t becomes 63
module ppg_pulse_gen
  import ppg_pkg::*;
#(
  parameter int unsigned RISE_DIV = 5,
  parameter int unsigned FALL_DIV = 10
) (
  input  logic           CLK,
  input  logic           rst_n,
  output logic [T_W-1:0] t,
  output logic           beat
);

  localparam int unsigned DIV_MAX = (RISE_DIV > FALL_DIV) ? RISE_DIV : FALL_DIV;
  localparam int PRE_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  logic             rise;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_last;

  assign pre_last = rise ? PRE_W'(RISE_DIV - 1) : PRE_W'(FALL_DIV - 1);

  // Direction flips on the step that lands on an end point, so t never wraps
  // and the prescaler restarts cleanly for the new slope.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      t    <= '0;
      rise <= 1'b1;
      pre  <= '0;
      beat <= 1'b0;
    end else begin
      beat <= 1'b0;
      if (pre == pre_last) begin
        pre <= '0;
        if (rise) begin
          t <= t + 1'b1;
          if (t == T_W'(62)) begin
            rise <= 1'b0;
            beat <= 1'b1;
          end
        end else begin
          t <= t - 1'b1;
          if (t == T_W'(1)) rise <= 1'b1;
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppg_afe_emulator.sv
// Closed-loop model of photodiode + DC compensation + PGA + ADC.
// Ports:
//   CLK, rst_n            : clock, async active-low reset
//   LED_RED, LED_IR       : LED enables from the settings controller
//   LED_DRIVE, DC_Comp,
//   PGA_Gain              : front-end settings from the controller
//   ADC                   : registered 8-bit converter code
//   beat                  : one-cycle strobe at the pulse peak
//   led_conflict          : sticky, set once both LEDs were seen on together
// Inputs registered at edge N reach ADC at edge N+3 (sample reg, stage 1, stage 2, ADC reg).
module ppg_afe_emulator
  import ppg_pkg::*;
#(
  parameter int unsigned RISE_DIV      = 5,
  parameter int unsigned FALL_DIV      = 10,
  parameter int unsigned DC_BASE_RED   = 200,
  parameter int unsigned DC_BASE_IR    = 240,
  parameter int unsigned AC_AMP_RED    = 16,
  parameter int unsigned AC_AMP_IR     = 24,
  parameter int unsigned COMP_SCALE    = 2,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned DARK_CODE     = 0
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               LED_RED,
  input  logic               LED_IR,
  input  logic [DRIVE_W-1:0] LED_DRIVE,
  input  logic [COMP_W-1:0]  DC_Comp,
  input  logic [PGA_W-1:0]   PGA_Gain,
  output logic [ADC_W-1:0]   ADC,
  output logic               beat,
  output logic               led_conflict
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef struct packed {
    logic                     act;
    logic [PGA_W-1:0]         gain;
    logic signed [DIFF_W-1:0] diff;
  } s1_t;

  typedef struct packed {
    logic                    act;
    logic signed [AMP_W-1:0] amp;
  } s2_t;

  logic [T_W-1:0] t;

  ppg_pulse_gen #(.RISE_DIV(RISE_DIV), .FALL_DIV(FALL_DIV)) u_pulse (
    .CLK  (CLK),
    .rst_n(rst_n),
    .t    (t),
    .beat (beat)
  );

  // ---------------- input sample ----------------
  ch_e                s_ch;
  logic [DRIVE_W-1:0] s_drive;
  logic [COMP_W-1:0]  s_comp;
  logic [PGA_W-1:0]   s_gain;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s_ch         <= CH_NONE;
      s_drive      <= '0;
      s_comp       <= '0;
      s_gain       <= '0;
      led_conflict <= 1'b0;
    end else begin
      s_ch         <= decode_sel(LED_RED, LED_IR);
      s_drive      <= LED_DRIVE;
      s_comp       <= DC_Comp;
      s_gain       <= PGA_Gain;
      led_conflict <= led_conflict | (LED_RED & LED_IR);
    end
  end

  // ---------------- channel FSM ----------------
  // cur_ch remembers which channel is settling/active so a switch RED<->IR
  // (or a change mid-settle) restarts the settle count.
  st_e              state, state_n;
  ch_e              cur_ch, cur_ch_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_DARK;
      cur_ch <= CH_NONE;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      cur_ch <= cur_ch_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cur_ch_n = cur_ch;
    cnt_n    = cnt;
    unique case (state)
      ST_DARK: begin
        if (s_ch != CH_NONE) begin
          state_n  = ST_SETTLE;
          cur_ch_n = s_ch;
          cnt_n    = '0;
        end
      end
      ST_SETTLE: begin
        if (s_ch == CH_NONE) begin
          state_n = ST_DARK;
        end else if (s_ch != cur_ch) begin
          cur_ch_n = s_ch;
          cnt_n    = '0;
        end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_n = ST_ACTIVE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (s_ch == CH_NONE) begin
          state_n = ST_DARK;
        end else if (s_ch != cur_ch) begin
          state_n  = ST_SETTLE;
          cur_ch_n = s_ch;
          cnt_n    = '0;
        end
      end
      default: state_n = ST_DARK;
    endcase
  end

  // ---------------- stage 1: photocurrent minus compensation ----------------
  // The active flag follows the FSM decision for this same sample, so the
  // very sample that leaves ACTIVE is already dark.
  logic [9:0]               dc_base, ac_amp, ac, photo;
  logic [DIFF_W-1:0]        comp_sub;
  logic signed [DIFF_W-1:0] diff;

  always_comb begin
    dc_base  = (s_ch == CH_IR) ? 10'(DC_BASE_IR) : 10'(DC_BASE_RED);
    ac_amp   = (s_ch == CH_IR) ? 10'(AC_AMP_IR)  : 10'(AC_AMP_RED);
    ac       = 10'((16'(ac_amp) * 16'(t)) >> 6);
    photo    = 10'(((16'(dc_base) + 16'(ac)) * 16'(s_drive)) >> 3);
    comp_sub = DIFF_W'(s_comp) * DIFF_W'(COMP_SCALE);
    diff     = $signed({2'b00, photo}) - $signed(comp_sub);
  end

  s1_t s1;
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) s1 <= '0;
    else        s1 <= '{act: (state_n == ST_ACTIVE), gain: s_gain, diff: diff};
  end

  // ---------------- stage 2: PGA ----------------
  logic [4:0]              gain_m;
  logic signed [AMP_W-1:0] amp;

  always_comb begin
    gain_m = {1'b0, s1.gain} + 5'd1;
    amp    = $signed(AMP_W'($signed(s1.diff))) * $signed(AMP_W'(gain_m));
  end

  s2_t s2;
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) s2 <= '0;
    else        s2 <= '{act: s1.act, amp: amp};
  end

  // ---------------- ADC: offset + saturate ----------------
  logic signed [AMP_W:0] sum;
  logic [ADC_W-1:0]      code;

  always_comb begin
    sum = (AMP_W+1)'($signed(s2.amp)) + $signed((AMP_W+1)'(ADC_MID));
    if (sum < $signed((AMP_W+1)'(ADC_MIN)))      code = ADC_W'(ADC_MIN);
    else if (sum > $signed((AMP_W+1)'(ADC_MAX))) code = ADC_W'(ADC_MAX);
    else                                         code = sum[ADC_W-1:0];
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) ADC <= ADC_W'(DARK_CODE);
    else        ADC <= s2.act ? code : ADC_W'(DARK_CODE);
  end

endmodule

// File: tb/tb_ppg_afe_emulator.sv
// Scoreboard bench: the driver schedules hand-computed expectations against
// absolute cycle numbers; a negedge monitor compares them as they come due.
module tb_ppg_afe_emulator;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       LED_RED = 1'b0, LED_IR = 1'b0;
  logic [3:0] LED_DRIVE = '0;
  logic [6:0] DC_Comp = '0;
  logic [3:0] PGA_Gain = '0;
  logic [7:0] ADC;
  logic       beat, led_conflict;

  ppg_afe_emulator dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .LED_RED     (LED_RED),
    .LED_IR      (LED_IR),
    .LED_DRIVE   (LED_DRIVE),
    .DC_Comp     (DC_Comp),
    .PGA_Gain    (PGA_Gain),
    .ADC         (ADC),
    .beat        (beat),
    .led_conflict(led_conflict)
  );

  always #5 CLK = ~CLK;

  // cyc == number of posedges seen; read at negedges
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam int K_ADC = 0, K_BEAT = 1, K_CONF = 2;
  typedef struct { int due; int kind; int exp; int id; } chk_t;
  chk_t  sb[$];
  string kname[3] = '{"adc", "beat", "conflict"};
  int    n_run = 0, n_fail = 0, n_id = 0;

  task automatic expect_at(input int due, input int kind, input int exp);
    chk_t c;
    c.due = due; c.kind = kind; c.exp = exp; c.id = n_id;
    n_id++;
    sb.push_back(c);
  endtask

  function automatic int observe(input int kind);
    case (kind)
      K_ADC:   return int'(ADC);
      K_BEAT:  return int'(beat);
      default: return int'(led_conflict);
    endcase
  endfunction

  // monitor
  initial begin
    forever begin
      @(negedge CLK);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          int act;
          act = observe(sb[i].kind);
          n_run++;
          if (sb[i].due < cyc) begin
            n_fail++;
            $display("FAIL %s#%0d not checked at due cycle %0d (now %0d)",
                     kname[sb[i].kind], sb[i].id, sb[i].due, cyc);
          end else if (act != sb[i].exp) begin
            n_fail++;
            $display("FAIL %s#%0d cycle %0d: got %0d, expected %0d",
                     kname[sb[i].kind], sb[i].id, cyc, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic wait_beat(output int b);
    int n = 0;
    @(negedge CLK);
    while (beat !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    n_run++;
    if (beat !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_wait: no beat within %0d cycles, got %0d, expected 1", n, beat);
    end
    b = cyc;
  endtask

  // driver
  initial begin
    int b, b2, b3, b4, r, x, n;

    // reset state; first beat 315 cycles after release
    expect_at(2, K_ADC, 0);
    expect_at(2, K_BEAT, 0);
    expect_at(2, K_CONF, 0);
    expect_at(317, K_BEAT, 0);
    expect_at(318, K_BEAT, 1);
    wait_cyc(3);
    rst_n = 1'b1;

    // RED lock at the peak (t=63 for the next 10 samples)
    wait_beat(b);
    LED_RED = 1'b1; LED_DRIVE = 4'd8; DC_Comp = 7'd100; PGA_Gain = 4'd0;
    for (int k = 1; k <= 6; k++) expect_at(b + k, K_ADC, 0);
    expect_at(b + 7,   K_ADC, 143);
    expect_at(b + 12,  K_ADC, 143);
    expect_at(b + 315, K_ADC, 136);   // t=32 mid-fall
    expect_at(b + 633, K_ADC, 128);   // t=0
    expect_at(b + 637, K_ADC, 128);
    expect_at(b + 944, K_BEAT, 0);
    expect_at(b + 945, K_BEAT, 1);
    expect_at(b + 946, K_BEAT, 0);
    wait_cyc(b + 640);

    // gain / DC_Comp sweep at the peak, no settle
    wait_beat(b2);
    PGA_Gain = 4'd15;
    expect_at(b2 + 3, K_ADC, 143);
    expect_at(b2 + 4, K_ADC, 255);
    expect_at(b2 + 5, K_ADC, 188);
    expect_at(b2 + 6, K_ADC, 255);
    expect_at(b2 + 7, K_ADC, 0);
    expect_at(b2 + 8, K_ADC, 143);
    expect_at(b2 + 633, K_ADC, 74);
    expect_at(b2 + 637, K_ADC, 74);
    wait_cyc(b2 + 1); PGA_Gain = 4'd3;
    wait_cyc(b2 + 2); PGA_Gain = 4'd0;  DC_Comp = 7'd0;
    wait_cyc(b2 + 3); PGA_Gain = 4'd15; DC_Comp = 7'd127;
    wait_cyc(b2 + 4); PGA_Gain = 4'd0;  DC_Comp = 7'd100;
    wait_cyc(b2 + 629); DC_Comp = 7'd127;
    wait_cyc(b2 + 640);

    // RED -> IR switch landing on t=0
    wait_beat(b3);
    x = b3 + 630;
    expect_at(x + 2, K_ADC, 74);
    expect_at(x + 3, K_ADC, 0);
    expect_at(x + 4, K_ADC, 0);
    expect_at(x + 5, K_ADC, 0);
    expect_at(x + 6, K_ADC, 128);
    expect_at(x + 7, K_ADC, 128);
    expect_at(x + 70, K_CONF, 0);
    expect_at(b3 + 948, K_ADC, 151);  // IR at t=63
    wait_cyc(b3 + 629);
    LED_RED = 1'b0; LED_IR = 1'b1; DC_Comp = 7'd120;
    wait_cyc(b3 + 640);

    // one-cycle conflict, then back to RED
    wait_beat(b4);
    LED_RED = 1'b1; DC_Comp = 7'd100;
    expect_at(b4 + 1,  K_CONF, 1);
    expect_at(b4 + 20, K_CONF, 1);
    expect_at(b4 + 4,  K_ADC, 0);
    expect_at(b4 + 7,  K_ADC, 0);
    expect_at(b4 + 8,  K_ADC, 143);
    wait_cyc(b4 + 1);
    LED_IR = 1'b0;

    // reset mid-pulse
    wait_cyc(b4 + 30);
    rst_n = 1'b0;
    expect_at(b4 + 31, K_ADC, 0);
    expect_at(b4 + 31, K_BEAT, 0);
    expect_at(b4 + 31, K_CONF, 0);
    wait_cyc(b4 + 33);
    rst_n = 1'b1;
    r = b4 + 33;
    expect_at(r + 1,   K_ADC, 0);
    expect_at(r + 6,   K_ADC, 0);
    expect_at(r + 7,   K_ADC, 128);
    expect_at(r + 10,  K_CONF, 0);
    expect_at(r + 314, K_BEAT, 0);
    expect_at(r + 315, K_BEAT, 1);
    wait_cyc(r + 320);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d checks never came due, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
